// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite types: response codes and the command-master state encoding.
// Imported by the master, the SRAM controller and the verification environment.
package axilite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } mst_state_t;

endpackage

// File: rtl/axilite_cmd_master.sv
// AXI4-Lite master: one read/write command in flight; response 3 cycles after command handshake with a zero-wait slave.
// Backpressure: cmd_ready only in IDLE; waits indefinitely on the slave; response held stable until rsp_ready.
module axilite_cmd_master
    import axilite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic                m_axi_bvalid,
    input  logic [1:0]          m_axi_bresp,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic                m_axi_rvalid,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    output logic                m_axi_rready
);

    mst_state_t        state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              aw_done, w_done;
    logic              cmd_hs, aw_hs, w_hs, b_hs, r_hs;

    // All handshake outputs decode registered state only, so no valid ever follows a ready combinationally.
    assign cmd_ready     = rst_n && (state == IDLE);
    assign m_axi_awvalid = (state == WR_AW_W) && !aw_done;
    assign m_axi_wvalid  = (state == WR_AW_W) && !w_done;
    assign m_axi_bready  = (state == WR_B);
    assign m_axi_arvalid = (state == RD_AR);
    assign m_axi_rready  = (state == RD_R);
    assign rsp_valid     = (state == RSP);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = m_axi_awvalid && m_axi_awready;
    assign w_hs   = m_axi_wvalid && m_axi_wready;
    assign b_hs   = m_axi_bvalid && m_axi_bready;
    assign r_hs   = m_axi_rvalid && m_axi_rready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_hs) state_nxt = cmd_write ? WR_AW_W : RD_AR;
            WR_AW_W: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_B;
            WR_B:    if (b_hs) state_nxt = RSP;
            RD_AR:   if (m_axi_arready) state_nxt = RD_R;
            RD_R:    if (r_hs) state_nxt = RSP;
            RSP:     if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            m_axi_wdata <= '0;
            m_axi_wstrb <= '0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b00;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else begin
            if (cmd_hs) begin
                addr_q      <= cmd_addr;
                m_axi_wdata <= cmd_wdata;
                m_axi_wstrb <= cmd_wstrb;
                rsp_write   <= cmd_write;
                rsp_rdata   <= '0;
                rsp_resp    <= 2'b00;
                aw_done     <= 1'b0;
                w_done      <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (b_hs)  rsp_resp <= m_axi_bresp;
            // Read data is returned even with an error response.
            if (r_hs) begin
                rsp_rdata <= m_axi_rdata;
                rsp_resp  <= m_axi_rresp;
            end
        end
    end

endmodule

// File: tb/tb_axilite_cmd_master.sv
// Directed bench for axilite_cmd_master with a behavioural AXI4-Lite memory slave.
module tb_axilite_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave configuration and bookkeeping
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int          n_aw = 0, n_w = 0, n_b = 0;
    logic        have_aw, have_w, have_ar;
    logic        aw_hs_p, w_hs_p, b_hs_p, ar_hs_p, r_hs_p;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    logic [31:0] mem [0:127];
    logic [31:0] mdl [0:7];

    always #5 clk = ~clk;

    axilite_cmd_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rready(m_axi_rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_clear();
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        m_axi_arready = 0; m_axi_rvalid = 0;
        have_aw = 0; have_w = 0; have_ar = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0; ar_hs_p = 0; r_hs_p = 0;
    endtask

    // Runs at each falling edge: retire handshakes of the last rising edge, then drive.
    task automatic slave_step();
        if (!rst_n) begin
            slave_clear();
        end else begin
            if (aw_hs_p) begin m_axi_awready = 0; have_aw = 1; n_aw++; end
            if (w_hs_p)  begin m_axi_wready  = 0; have_w  = 1; n_w++;  end
            if (b_hs_p)  begin m_axi_bvalid  = 0; n_b++; end
            if (ar_hs_p) begin m_axi_arready = 0; have_ar = 1; end
            if (r_hs_p)  m_axi_rvalid = 0;
            if (m_axi_awvalid && !m_axi_awready && !have_aw) begin
                if (aw_cnt >= aw_wait) m_axi_awready = 1; else aw_cnt++;
            end
            if (m_axi_wvalid && !m_axi_wready && !have_w) begin
                if (w_cnt >= w_wait) m_axi_wready = 1; else w_cnt++;
            end
            if (have_aw && have_w && !m_axi_bvalid) begin
                if (b_cnt >= b_wait) begin
                    for (int i = 0; i < 4; i++)
                        if (cap_wstrb[i]) mem[cap_awaddr[8:2]][8*i +: 8] = cap_wdata[8*i +: 8];
                    m_axi_bvalid = 1; m_axi_bresp = bresp_cfg;
                    have_aw = 0; have_w = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                end else b_cnt++;
            end
            if (m_axi_arvalid && !m_axi_arready && !have_ar) begin
                if (ar_cnt >= ar_wait) m_axi_arready = 1; else ar_cnt++;
            end
            if (have_ar && !m_axi_rvalid) begin
                if (r_cnt >= r_wait) begin
                    m_axi_rvalid = 1; m_axi_rdata = mem[cap_araddr[8:2]]; m_axi_rresp = rresp_cfg;
                    have_ar = 0; ar_cnt = 0; r_cnt = 0;
                end else r_cnt++;
            end
            aw_hs_p = m_axi_awvalid && m_axi_awready;
            w_hs_p  = m_axi_wvalid && m_axi_wready;
            b_hs_p  = m_axi_bvalid && m_axi_bready;
            ar_hs_p = m_axi_arvalid && m_axi_arready;
            r_hs_p  = m_axi_rvalid && m_axi_rready;
            if (aw_hs_p) cap_awaddr = m_axi_awaddr;
            if (w_hs_p) begin cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; end
            if (ar_hs_p) cap_araddr = m_axi_araddr;
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        m_axi_bresp = 2'b00; m_axi_rresp = 2'b00; m_axi_rdata = '0;
        cap_awaddr = '0; cap_wdata = '0; cap_wstrb = '0; cap_araddr = '0;
        slave_clear();
        forever begin
            @(negedge clk);
            slave_step();
        end
    end

    // Called at a falling edge; returns at the falling edge after the command handshake.
    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("cmd_ready before accept", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("rsp_valid within bound", rsp_valid, 1);
    endtask

    initial begin
        int          cyc, idx;
        logic        wr;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] a;

        for (int i = 0; i < 8; i++) mdl[i] = '0;
        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst cmd_ready", cmd_ready, 0);
        check("rst valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 0);
        check("rst readies", {m_axi_bready, m_axi_rready}, 0);
        check("rst addr/data", {m_axi_awaddr, m_axi_araddr}, 0);
        check("rst rsp fields", {rsp_rdata, rsp_resp, rsp_write}, 0);
        rst_n = 1;
        @(negedge clk);
        check("idle cmd_ready", cmd_ready, 1);

        // Zero-wait write: AW/W at T1, bready at T2, rsp at T3
        send_cmd(1, 32'h10, 32'hDEADBEEF, 4'hF);
        check("wr T1 awvalid/wvalid", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        check("wr T1 awaddr", m_axi_awaddr, 32'h10);
        check("wr T1 wdata", m_axi_wdata, 32'hDEADBEEF);
        check("wr T1 wstrb", m_axi_wstrb, 4'hF);
        check("wr T1 cmd_ready", cmd_ready, 0);
        @(negedge clk);
        check("wr T2 bready", m_axi_bready, 1);
        check("wr T2 valids dropped", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
        @(negedge clk);
        check("wr T3 rsp_valid", rsp_valid, 1);
        check("wr T3 rsp fields", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0});
        check("wr T3 bready", m_axi_bready, 0);
        @(negedge clk);
        check("wr T4 rsp_valid low", rsp_valid, 0);
        check("wr T4 cmd_ready", cmd_ready, 1);

        // Read with 3 slave wait cycles on R
        r_wait = 3;
        send_cmd(0, 32'h10, 32'h0, 4'h0);
        check("rd T1 arvalid", m_axi_arvalid, 1);
        check("rd T1 araddr", m_axi_araddr, 32'h10);
        @(negedge clk);
        check("rd T2 arvalid/rready", {m_axi_arvalid, m_axi_rready}, 2'b01);
        cyc = 2;
        while (rsp_valid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        check("rd latency", cyc, 6);
        check("rd rdata", rsp_rdata, 32'hDEADBEEF);
        check("rd write/resp", {rsp_write, rsp_resp}, 3'b000);
        @(negedge clk);
        r_wait = 0;

        // Independent AW/W completion: k=0 AW first, k=1 W first
        for (int k = 0; k < 2; k++) begin
            int aw0, w0, b0;
            aw_wait = (k == 0) ? 0 : 2;
            w_wait  = (k == 0) ? 2 : 0;
            aw0 = n_aw; w0 = n_w; b0 = n_b;
            send_cmd(1, 32'h20 + 4 * k, 32'h12345678 + k, 4'hF);
            check("split T1 both valid", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
            @(negedge clk);
            check("split T2 awvalid", m_axi_awvalid, k);
            check("split T2 wvalid", m_axi_wvalid, 1 - k);
            @(negedge clk);
            check("split T3 valids", {m_axi_awvalid, m_axi_wvalid}, (k == 0) ? 2'b01 : 2'b10);
            @(negedge clk);
            check("split T4 valids/bready", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
            wait_rsp();
            check("split rsp", {rsp_write, rsp_resp}, 3'b100);
            @(negedge clk);
            check("split rsp once", rsp_valid, 0);
            @(negedge clk);
            check("split handshake counts", {n_aw - aw0, n_w - w0, n_b - b0}, {32'd1, 32'd1, 32'd1});
        end
        aw_wait = 0; w_wait = 0;

        // Error response with held-off response consumer
        bresp_cfg = 2'b10; rsp_ready = 0;
        send_cmd(1, 32'h28, 32'hCAFEF00D, 4'h3);
        wait_rsp();
        for (int i = 0; i < 4; i++) begin
            check("hold rsp_valid", rsp_valid, 1);
            check("hold rsp_resp", rsp_resp, 2'b10);
            check("hold cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1; bresp_cfg = 2'b00;
        @(negedge clk);
        check("release rsp_valid", rsp_valid, 0);
        check("release cmd_ready", cmd_ready, 1);

        // Read error keeps data
        rresp_cfg = 2'b11;
        send_cmd(0, 32'h10, 32'h0, 4'h0);
        wait_rsp();
        check("rderr rdata", rsp_rdata, 32'hDEADBEEF);
        check("rderr resp", rsp_resp, 2'b11);
        @(negedge clk);
        rresp_cfg = 2'b00;

        // Reset while waiting in RD_R
        r_wait = 10;
        send_cmd(0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        check("rdr rready before reset", m_axi_rready, 1);
        rst_n = 0;
        @(negedge clk);
        check("rdr valids after reset", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 0);
        check("rdr readies after reset", {m_axi_bready, m_axi_rready}, 0);
        check("rdr cmd_ready in reset", cmd_ready, 0);
        @(negedge clk);
        rst_n = 1; r_wait = 0;
        @(negedge clk);
        check("rdr cmd_ready after reset", cmd_ready, 1);

        // Back-to-back random traffic in 0x100..0x11C, compared against a byte-merge model
        for (int t = 0; t < 100; t++) begin
            aw_wait = $urandom_range(0, 2); w_wait = $urandom_range(0, 2);
            b_wait  = $urandom_range(0, 2); ar_wait = $urandom_range(0, 2);
            r_wait  = $urandom_range(0, 2);
            idx = $urandom_range(0, 7);
            wr  = 1'($urandom_range(0, 1));
            d   = $urandom;
            s   = 4'($urandom_range(1, 15));
            a   = 32'h100 + 32'(idx * 4);
            send_cmd(wr, a, d, s);
            wait_rsp();
            if (wr) begin
                check("rand wr rsp", {rsp_write, rsp_resp}, 3'b100);
                for (int i = 0; i < 4; i++) if (s[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
            end else begin
                check("rand rd rsp", {rsp_write, rsp_resp}, 3'b000);
                check("rand rd data", rsp_rdata, mdl[idx]);
            end
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
